// File: rtl/la_nandtree_pkg.sv
// Shared elaboration-time helpers for the NAND reduction tree: level counts,
// padded operand counts and the layout of the inter-stage data bus.
package la_nandtree_pkg;

    // Smallest L with 2**L >= n.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Operand count after padding up to a power of two.
    function automatic int pad_ops(input int n);
        return 1 << clog2(n);
    endfunction

    // AND levels handled by each register group; the last group takes what is left.
    function automatic int levels_per_stage(input int n, input int stages);
        if (stages <= 0) begin
            return 0;
        end
        return (clog2(n) + stages - 1) / stages;
    endfunction

    // Operands still live at the input of group k (k = stages means the final output).
    function automatic int ops_at(input int n, input int stages, input int k);
        int lv;
        lv = k * levels_per_stage(n, stages);
        if (lv > clog2(n)) begin
            lv = clog2(n);
        end
        return pad_ops(n) >> lv;
    endfunction

    // Bit offset of segment k in the concatenated inter-stage bus.
    function automatic int seg_off(input int n, input int stages, input int w, input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s = s + ops_at(n, stages, j) * w;
        end
        return s;
    endfunction

endpackage

// File: rtl/la_nandtree_stage.sv
// One elastic stage of the reduction tree: LEVELS levels of 2-input AND
// folding IN_OPS operands down to OUT_OPS, followed by a valid/data register.
// The stage's load permission (i_ready) is computed by the parent so the
// ready chain stays a flat function of the stage valid bits.
module la_nandtree_stage
    import la_nandtree_pkg::*;
#(
    parameter int IN_OPS  = 2,
    parameter int OUT_OPS = 1,
    parameter int W       = 8,
    parameter int LEVELS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_nreset,
    input  logic                 i_valid,
    input  logic                 i_ready,
    input  logic [IN_OPS*W-1:0]  i_data,
    output logic                 o_valid,
    output logic [OUT_OPS*W-1:0] o_data
);

    localparam int GRP = 1 << LEVELS;

    if (OUT_OPS * GRP != IN_OPS) begin : g_bad_shape
        $error("la_nandtree_stage: IN_OPS must equal OUT_OPS << LEVELS");
    end

    logic [OUT_OPS*W-1:0] w_and;
    logic                 r_vld;
    logic [OUT_OPS*W-1:0] r_data;

    // Each output operand is the AND of a contiguous group of 2**LEVELS inputs.
    always_comb begin
        w_and = '1;
        for (int j = 0; j < OUT_OPS; j++) begin
            for (int i = 0; i < GRP; i++) begin
                w_and[j*W +: W] = w_and[j*W +: W] & i_data[(j*GRP+i)*W +: W];
            end
        end
    end

    // Valid bit: cleared by reset, reloaded whenever the stage may take a bundle.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_vld <= 1'b0;
        end else if (i_ready) begin
            r_vld <= i_valid;
        end
    end

    // Data only moves on an actual transfer; it is meaningless while r_vld is low.
    always_ff @(posedge i_clk) begin
        if (i_valid && i_ready) begin
            r_data <= w_and;
        end
    end

    assign o_valid = r_vld;
    assign o_data  = r_data;

endmodule

// File: rtl/la_nandtree_pipe.sv
// N-input, W-lane bitwise NAND (or AND) reduction with STAGES elastic
// register groups. Operands beyond N are padded with ones so they never
// affect the result. STAGES=0 gives a purely combinational tree.
module la_nandtree_pipe
    import la_nandtree_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int STAGES = 1,
    parameter int INV    = 1,
    parameter     PROP   = "DEFAULT"
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   z
);

    localparam int L     = clog2(N);
    localparam int NP    = pad_ops(N);
    localparam int W_PAD = NP * W;

    if (N < 2) begin : g_bad_n
        $error("la_nandtree_pipe: N must be at least 2");
    end
    if (STAGES < 0 || STAGES > L) begin : g_bad_stages
        $error("la_nandtree_pipe: STAGES must be in 0..ceil(log2 N)");
    end
    if (PROP == "") begin : g_bad_prop
        $error("la_nandtree_pipe: PROP must name an implementation property");
    end

    logic [W_PAD-1:0] w_pad;
    logic [W-1:0]     w_red;

    // Pad missing operands with all-ones so they are neutral for AND.
    always_comb begin
        w_pad = '1;
        w_pad[N*W-1:0] = a;
    end

    if (STAGES == 0) begin : g_comb
        // Whole tree in one combinational cone; handshake passes straight through.
        always_comb begin
            w_red = '1;
            for (int k = 0; k < NP; k++) begin
                w_red = w_red & w_pad[k*W +: W];
            end
        end
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
    end else begin : g_pipe
        localparam int BUS_W = seg_off(N, STAGES, W, STAGES + 1);

        logic [BUS_W-1:0] w_bus;
        logic [STAGES:0]  w_vld;
        logic [STAGES:0]  w_full;
        logic [STAGES-1:0] w_rdy;

        assign w_bus[W_PAD-1:0] = w_pad;
        assign w_vld[0]         = in_valid;

        // Stage s may load unless it and every stage after it are full and the
        // sink is stalled; this is ~vld[s] | ready[s+1] unrolled.
        always_comb begin
            w_full = '0;
            w_rdy  = '0;
            w_full[STAGES] = 1'b1;
            for (int j = STAGES - 1; j >= 0; j--) begin
                w_full[j] = w_full[j+1] & w_vld[j+1];
                w_rdy[j]  = out_ready | ~w_full[j];
            end
        end

        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            localparam int OPS_I = ops_at(N, STAGES, g);
            localparam int OPS_O = ops_at(N, STAGES, g + 1);
            localparam int OFF_I = seg_off(N, STAGES, W, g);
            localparam int OFF_O = seg_off(N, STAGES, W, g + 1);
            localparam int LV    = clog2(OPS_I) - clog2(OPS_O);

            la_nandtree_stage #(
                .IN_OPS (OPS_I),
                .OUT_OPS(OPS_O),
                .W      (W),
                .LEVELS (LV)
            ) u_stage (
                .i_clk   (clk),
                .i_nreset(nreset),
                .i_valid (w_vld[g]),
                .i_ready (w_rdy[g]),
                .i_data  (w_bus[OFF_I +: OPS_I*W]),
                .o_valid (w_vld[g+1]),
                .o_data  (w_bus[OFF_O +: OPS_O*W])
            );
        end

        assign w_red     = w_bus[seg_off(N, STAGES, W, STAGES) +: W];
        assign out_valid = w_vld[STAGES];
        assign in_ready  = w_rdy[0];
    end

    // Final inversion sits after the last register.
    assign z = (INV != 0) ? ~w_red : w_red;

endmodule
